// File: rtl/kmeans_pkg.sv
// k-means k=3 n=2 controller package.
// FSM state encodings and counter-width helper.
package kmeans_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // One extra bit so a full pass count is representable.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/kmeans_addr_counter.sv
// Enable/clear up-counter with terminal-count flag.
// Used for point addresses and returned-result counting.
module kmeans_addr_counter
  import kmeans_pkg::*;
#(
  parameter int          W    = 8,
  parameter int unsigned TERM = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Count up on enable; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(TERM));

endmodule

// File: rtl/kmeans_k3n2_ctrl.sv
// k-means k=3 n=2 iteration sequencer.
// Streams points, counts results, runs update, decides next pass.
module kmeans_k3n2_ctrl
  import kmeans_pkg::*;
#(
  parameter int input_data_qty_bit_width = 8,
  parameter int input_data_qty           = 256,
  parameter int iter_width               = 8,
  parameter int max_iter                 = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                mem_rd_en,
  output logic [input_data_qty_bit_width-1:0] mem_rd_addr,
  output logic                                acc_clr,
  input  logic                                res_valid,
  input  logic                                res_changed,
  output logic                                upd_start,
  input  logic                                upd_done,
  output logic                                busy,
  output logic                                done,
  output logic                                converged,
  output logic [iter_width-1:0]               iter_count,
  output logic                                err
);

  localparam int RW = cnt_width(input_data_qty_bit_width);

  logic [2:0]            state;
  logic [2:0]            nxt;
  logic [RW-1:0]         res_cnt;
  logic                  addr_tc;
  logic                  res_tc;
  logic                  res_last;
  logic                  counting;
  logic                  res_take;
  logic                  res_bad;
  logic                  idle_like;
  logic                  go;
  logic                  any_changed;
  logic                  upd_pend;
  logic [iter_width-1:0] iter_inc;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign go        = idle_like && start;
  assign counting  = (state == S_STREAM) || (state == S_DRAIN);
  assign res_take  = res_valid && counting && !res_tc;
  assign res_bad   = res_valid && !res_take;
  assign res_last  = (res_cnt == RW'(input_data_qty - 1));
  assign iter_inc  = (iter_count == '1) ? iter_count
                                        : iter_count + 1'b1;

  kmeans_addr_counter #(
    .W    (input_data_qty_bit_width),
    .TERM (input_data_qty - 1)
  ) u_addr (
    .clk (clk),
    .rst (rst),
    .clr (state == S_CLEAR),
    .en  ((state == S_STREAM) && !addr_tc),
    .cnt (mem_rd_addr),
    .tc  (addr_tc)
  );

  kmeans_addr_counter #(
    .W    (RW),
    .TERM (input_data_qty)
  ) u_res (
    .clk (clk),
    .rst (rst),
    .clr (state == S_CLEAR),
    .en  (res_take),
    .cnt (res_cnt),
    .tc  (res_tc)
  );

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) nxt = S_CLEAR;
      S_CLEAR:        nxt = S_STREAM;
      S_STREAM:       if (addr_tc) nxt = S_DRAIN;
      S_DRAIN: begin
        if (res_tc || (res_take && res_last)) nxt = S_UPDATE;
      end
      S_UPDATE:       if (upd_done) nxt = S_CHECK;
      S_CHECK: begin
        if (!any_changed) begin
          nxt = S_DONE;
        end else if (iter_inc >= iter_width'(max_iter)) begin
          nxt = S_DONE;
        end else begin
          nxt = S_CLEAR;
        end
      end
      default:        nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Update kick: high only for the first UPDATE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_pend <= 1'b0;
    end else begin
      upd_pend <= (nxt == S_UPDATE) && (state != S_UPDATE);
    end
  end

  // Per-pass change tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_changed <= 1'b0;
    end else if (state == S_CLEAR) begin
      any_changed <= 1'b0;
    end else if (res_take && res_changed) begin
      any_changed <= 1'b1;
    end
  end

  // Run status: iteration count, convergence, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_count <= '0;
      converged  <= 1'b0;
      err        <= 1'b0;
    end else if (go) begin
      iter_count <= '0;
      converged  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (res_bad) begin
        err <= 1'b1;
      end
      if (state == S_CHECK) begin
        iter_count <= iter_inc;
        converged  <= !any_changed;
      end
    end
  end

  assign mem_rd_en = (state == S_STREAM);
  assign acc_clr   = (state == S_CLEAR);
  assign upd_start = upd_pend;
  assign busy      = !idle_like;
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_kmeans_k3n2_ctrl.sv
// Directed bench for kmeans_k3n2_ctrl.
// Two instances: long cap (convergence) and max_iter=3 (cap).
module tb_kmeans_k3n2_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       upd_done = 1'b1;

  logic       start_a = 1'b0;
  logic       en_a;
  logic [2:0] addr_a;
  logic       clr_a;
  logic       rv_a;
  logic       chg_a = 1'b1;
  logic       inj_a = 1'b0;
  logic       upd_a;
  logic       busy_a;
  logic       done_a;
  logic       conv_a;
  logic [7:0] iter_a;
  logic       err_a;
  logic [3:0] pipe_a;

  logic       start_b = 1'b0;
  logic       en_b;
  logic [2:0] addr_b;
  logic       clr_b;
  logic       rv_b;
  logic       upd_b;
  logic       busy_b;
  logic       done_b;
  logic       conv_b;
  logic [7:0] iter_b;
  logic       err_b;
  logic [3:0] pipe_b;

  int nchecks = 0;
  int nerr = 0;

  int cyc = 0;
  int exp_addr = 0;
  int acc_n = 0;
  int upd_n = 0;
  int en_n = 0;
  int addr_bad = 0;
  int gap_bad = 0;
  int last_en = 0;
  int upd_cyc = 0;
  bit aft_upd = 0;
  bit upd_prev = 0;
  bit tim_en = 1;

  always #5 clk = ~clk;

  kmeans_k3n2_ctrl #(
    .input_data_qty_bit_width (3),
    .input_data_qty           (8),
    .iter_width               (8),
    .max_iter                 (32)
  ) dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start_a),
    .mem_rd_en   (en_a),
    .mem_rd_addr (addr_a),
    .acc_clr     (clr_a),
    .res_valid   (rv_a),
    .res_changed (chg_a),
    .upd_start   (upd_a),
    .upd_done    (upd_done),
    .busy        (busy_a),
    .done        (done_a),
    .converged   (conv_a),
    .iter_count  (iter_a),
    .err         (err_a)
  );

  kmeans_k3n2_ctrl #(
    .input_data_qty_bit_width (3),
    .input_data_qty           (8),
    .iter_width               (8),
    .max_iter                 (3)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start_b),
    .mem_rd_en   (en_b),
    .mem_rd_addr (addr_b),
    .acc_clr     (clr_b),
    .res_valid   (rv_b),
    .res_changed (1'b1),
    .upd_start   (upd_b),
    .upd_done    (upd_done),
    .busy        (busy_b),
    .done        (done_b),
    .converged   (conv_b),
    .iter_count  (iter_b),
    .err         (err_b)
  );

  // Datapath model: each issued address returns 4 cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_a <= '0;
      pipe_b <= '0;
    end else begin
      pipe_a <= {pipe_a[2:0], en_a};
      pipe_b <= {pipe_b[2:0], en_b};
    end
  end

  assign rv_a = pipe_a[3] | inj_a;
  assign rv_b = pipe_b[3];

  // Observe pulses, address order and handshake spacing on dut_a.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (clr_a) begin
      acc_n++;
      exp_addr = 0;
      if (aft_upd && tim_en && (cyc - upd_cyc != 2)) gap_bad++;
      aft_upd = 0;
    end
    if (en_a) begin
      en_n++;
      if (addr_a !== exp_addr[2:0]) addr_bad++;
      exp_addr++;
      last_en = cyc;
    end
    if (upd_a) begin
      upd_n++;
      if (upd_prev) gap_bad++;
      if (tim_en && (cyc - last_en != 5)) gap_bad++;
      upd_cyc = cyc;
      aft_upd = 1;
    end
    upd_prev = upd_a;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return upd_a;
      1:       return done_a;
      default: return done_b;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (sel_sig(sel)) hit = 1;
      else step();
    end
    nchecks++;
    assert (hit) else begin
      nerr++;
      $error("FAIL wait_%0d observed=timeout expected=event", sel);
    end
  endtask

  int acc0, upd0, en0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", en_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_clr", clr_a, 0);
    chk("rst_upd", upd_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_conv", conv_a, 0);
    chk("rst_iter", iter_a, 0);
    chk("rst_err", err_a, 0);
    rst = 1'b0;
    step();

    acc0 = acc_n;
    upd0 = upd_n;
    en0 = en_n;
    start_a = 1'b1;
    start_b = 1'b1;
    step();
    chk("clear_pulse", clr_a, 1);
    chk("clear_busy", busy_a, 1);
    start_a = 1'b0;
    start_b = 1'b0;
    step();
    chk("stream_a0", addr_a, 0);
    step();
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("start_ign_addr", addr_a, 3);
    chk("start_ign_en", en_a, 1);
    chk("start_ign_iter", iter_a, 0);

    for (int p = 0; p < 3; p++) begin
      wait_for(0, 40);
      step();
    end
    chg_a = 1'b0;
    wait_for(1, 60);
    chk("conv_done", done_a, 1);
    chk("conv_conv", conv_a, 1);
    chk("conv_iter", iter_a, 4);
    chk("conv_busy", busy_a, 0);
    chk("conv_clr_n", acc_n - acc0, 4);
    chk("conv_upd_n", upd_n - upd0, 4);
    chk("conv_en_n", en_n - en0, 32);
    chk("conv_addr", addr_bad, 0);
    chk("conv_timing", gap_bad, 0);
    chk("conv_err", err_a, 0);

    wait_for(2, 20);
    chk("cap_done", done_b, 1);
    chk("cap_conv", conv_b, 0);
    chk("cap_iter", iter_b, 3);

    tim_en = 0;
    step();
    chk("done_hold", done_a, 1);
    chk("done_hold_iter", iter_a, 4);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("restart_clr", clr_a, 1);
    chk("restart_iter", iter_a, 0);
    chk("restart_conv", conv_a, 0);
    chk("restart_done", done_a, 0);
    step();
    inj_a = 1'b1;
    chk("ovf_s_en", en_a, 1);
    repeat (4) step();
    inj_a = 1'b0;
    repeat (4) step();
    chk("ovf_drain_en", en_a, 0);
    chk("ovf_err_pre", err_a, 0);
    step();
    chk("ovf_err", err_a, 1);
    chk("ovf_upd", upd_a, 1);
    wait_for(1, 40);
    chk("ovf_conv", conv_a, 1);
    chk("ovf_iter", iter_a, 1);

    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (6) step();
    chk("mid_addr", addr_a, 5);
    rst = 1'b1;
    #1;
    chk("mrst_en", en_a, 0);
    chk("mrst_addr", addr_a, 0);
    chk("mrst_clr", clr_a, 0);
    chk("mrst_upd", upd_a, 0);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_done", done_a, 0);
    chk("mrst_err", err_a, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    inj_a = 1'b1;
    step();
    inj_a = 1'b0;
    chk("idle_err", err_a, 1);
    chk("idle_busy", busy_a, 0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("post_clr", clr_a, 1);
    chk("post_err", err_a, 0);
    step();
    chk("post_en", en_a, 1);
    chk("post_addr", addr_a, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
